// File: rtl/rv32m_muldiv.sv
// Iterative RV32M multiply/divide unit: 32-step shift-add multiply and restoring divide.
// Define MULDIV_FAST_MUL_EN to replace the iterative multiply with a single-cycle array multiply.
module rv32m_muldiv (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] busA,
  input  logic [31:0] busB,
  input  logic [4:0]  rd,
  output logic        busy,
  output logic        done,
  output logic [31:0] busW,
  output logic [4:0]  rw,
  output logic        regwr
);

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [2:0] OP_REMU   = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic logic [31:0] neg32(input logic [31:0] v);
    return ~v + 32'd1;
  endfunction

  function automatic logic [63:0] neg64(input logic [63:0] v);
    return ~v + 64'd1;
  endfunction

  // Applies sign fix-up to the unsigned magnitudes and picks the word funct3 asks for.
  function automatic logic [31:0] sel_result(
    input logic [2:0]  f3,
    input logic [63:0] prod,
    input logic [31:0] quo,
    input logic [31:0] rem,
    input logic        sa,
    input logic        sb
  );
    logic [63:0] p;
    logic [31:0] q;
    logic [31:0] r;
    logic [31:0] res;
    p = (sa ^ sb) ? neg64(prod) : prod;
    q = (sa ^ sb) ? neg32(quo) : quo;
    r = sa ? neg32(rem) : rem;
    case (f3)
      OP_MUL:                       res = p[31:0];
      OP_MULH, OP_MULHSU, OP_MULHU: res = p[63:32];
      OP_DIV, OP_DIVU:              res = q;
      OP_REM, OP_REMU:              res = r;
      default:                      res = 32'd0;
    endcase
    return res;
  endfunction

  state_t      state_r;
  state_t      next_state_s;

  logic [2:0]  op_r;
  logic [4:0]  rd_r;
  logic [31:0] mag_a_r;
  logic [31:0] mag_b_r;
  logic        neg_a_r;
  logic        neg_b_r;
  logic [4:0]  cnt_r;
  logic [63:0] prod_r;
  logic [31:0] rem_r;
  logic [31:0] quo_r;

  logic        a_signed_s;
  logic        b_signed_s;
  logic        neg_a_s;
  logic        neg_b_s;
  logic [31:0] mag_a_s;
  logic [31:0] mag_b_s;
  logic        div_zero_s;
  logic        div_ovf_s;
  logic        special_s;
  logic [31:0] special_res_s;
  logic        fast_s;
  logic [31:0] fast_res_s;

  logic [32:0] sum_s;
  logic [63:0] step_prod_s;
  logic [32:0] shift_s;
  logic        ge_s;
  logic [31:0] diff_s;
  logic [31:0] step_rem_s;
  logic [31:0] step_quo_s;

  logic        load_s;
  logic        step_s;
  logic        finish_s;
  logic [31:0] result_s;
  logic [4:0]  rw_next_s;

  // Operand decode on the raw inputs: signedness, magnitudes and divide special cases.
  always_comb begin
    a_signed_s = (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
    b_signed_s = (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
    neg_a_s    = a_signed_s && busA[31];
    neg_b_s    = b_signed_s && busB[31];
    mag_a_s    = neg_a_s ? neg32(busA) : busA;
    mag_b_s    = neg_b_s ? neg32(busB) : busB;
    div_zero_s = op[2] && (busB == 32'd0);
    div_ovf_s  = ((op == OP_DIV) || (op == OP_REM)) &&
                 (busA == 32'h8000_0000) && (busB == 32'hFFFF_FFFF);
    special_s  = div_zero_s || div_ovf_s;
    if (div_zero_s) begin
      special_res_s = op[1] ? busA : 32'hFFFF_FFFF;
    end else begin
      special_res_s = op[1] ? 32'd0 : 32'h8000_0000;
    end
  end

`ifdef MULDIV_FAST_MUL_EN
  logic [63:0] fast_prod_s;
  assign fast_prod_s = {32'd0, mag_a_s} * {32'd0, mag_b_s};
  assign fast_s      = !op[2];
  assign fast_res_s  = sel_result(op, fast_prod_s, 32'd0, 32'd0, neg_a_s, neg_b_s);
`else
  assign fast_s      = 1'b0;
  assign fast_res_s  = 32'd0;
`endif

  // One iteration of both datapaths; the op decides which one is used at the end.
  always_comb begin
    sum_s       = {1'b0, prod_r[63:32]} + (prod_r[0] ? {1'b0, mag_a_r} : 33'd0);
    step_prod_s = {sum_s, prod_r[31:1]};
    shift_s     = {rem_r, quo_r[31]};
    ge_s        = shift_s >= {1'b0, mag_b_r};
    diff_s      = shift_s[31:0] - mag_b_r;
    if (ge_s) begin
      step_rem_s = diff_s;
    end else begin
      step_rem_s = shift_s[31:0];
    end
    step_quo_s  = {quo_r[30:0], ge_s};
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          next_state_s = (special_s || fast_s) ? DONE : RUN;
        end else begin
          next_state_s = IDLE;
        end
      end
      RUN: begin
        if (cnt_r == 5'd31) begin
          next_state_s = DONE;
        end else begin
          next_state_s = RUN;
        end
      end
      DONE:    next_state_s = IDLE;
      default: next_state_s = IDLE;
    endcase
  end

  // Output/control decode: load, step, and the result to register on completion.
  always_comb begin
    load_s    = 1'b0;
    step_s    = 1'b0;
    finish_s  = 1'b0;
    result_s  = 32'd0;
    rw_next_s = rd_r;
    case (state_r)
      IDLE: begin
        rw_next_s = rd;
        if (start && special_s) begin
          finish_s = 1'b1;
          result_s = special_res_s;
        end else if (start && fast_s) begin
          finish_s = 1'b1;
          result_s = fast_res_s;
        end else if (start) begin
          load_s = 1'b1;
        end else begin
          load_s = 1'b0;
        end
      end
      RUN: begin
        step_s = 1'b1;
        if (cnt_r == 5'd31) begin
          finish_s = 1'b1;
          result_s = sel_result(op_r, step_prod_s, step_quo_s, step_rem_s, neg_a_r, neg_b_r);
        end else begin
          finish_s = 1'b0;
        end
      end
      DONE:    finish_s = 1'b0;
      default: finish_s = 1'b0;
    endcase
  end

  // Datapath registers and registered write-back outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_r    <= 3'd0;
      rd_r    <= 5'd0;
      mag_a_r <= 32'd0;
      mag_b_r <= 32'd0;
      neg_a_r <= 1'b0;
      neg_b_r <= 1'b0;
      cnt_r   <= 5'd0;
      prod_r  <= 64'd0;
      rem_r   <= 32'd0;
      quo_r   <= 32'd0;
      busy    <= 1'b0;
      done    <= 1'b0;
      regwr   <= 1'b0;
      busW    <= 32'd0;
      rw      <= 5'd0;
    end else begin
      if (load_s) begin
        op_r    <= op;
        rd_r    <= rd;
        mag_a_r <= mag_a_s;
        mag_b_r <= mag_b_s;
        neg_a_r <= neg_a_s;
        neg_b_r <= neg_b_s;
        cnt_r   <= 5'd0;
        prod_r  <= {32'd0, mag_b_s};
        rem_r   <= 32'd0;
        quo_r   <= mag_a_s;
      end else if (step_s) begin
        cnt_r  <= cnt_r + 5'd1;
        prod_r <= step_prod_s;
        rem_r  <= step_rem_s;
        quo_r  <= step_quo_s;
      end
      busy  <= (next_state_s != IDLE);
      done  <= finish_s;
      regwr <= finish_s && (rw_next_s != 5'd0);
      if (finish_s) begin
        busW <= result_s;
        rw   <= rw_next_s;
      end
    end
  end

endmodule
